display_source_select: RTL and testbench

Feeds the 32-bit `data` input of the eight-digit seven-segment `Display` block on the CPU board. It latches values the CPU emits through its display syscall, tracks the PC, a run-cycle counter and a syscall counter. It selects one of these four views with a debounced board push-button and presents the result as a registered 32-bit word.

---
 rtl/display_source_select.sv | 121 ++++++++++++
 tb/tb_display_source_select.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_select.sv
// display_source_select: picks one of four CPU debug views for the
// seven-segment display. A debounced push-button cycles the view. The
// outputs (syscall value, PC, run cycles, syscall count) are registered
// 32-bit words.
module display_source_select #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_value,
    input  logic [31:0] pc,
    input  logic        halted,
    input  logic        mode_button,
    output logic [31:0] data,
    output logic [1:0]  mode
);

    // Terminal count of the debouncer. The counter is 24 bits wide, so the
    // parameter range is bounded accordingly.
    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic        sync_a;
    logic        sync_b;
    logic [23:0] db_cnt;
    logic        db_state;
    logic        db_state_d;
    logic        press;
    logic [31:0] sys_val;
    logic [31:0] sys_cnt;
    logic [31:0] cyc_cnt;
    logic [31:0] pc_q;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= mode_button;
            sync_b <= sync_a;
        end
    end

    // Debouncer: accept a new level only after it has persisted long enough
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt   <= '0;
            db_state <= 1'b0;
        end else if (sync_b == db_state) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_state <= sync_b;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 24'd1;
        end
    end

    // One-cycle press pulse on the debounced rising edge only
    always_ff @(posedge clock) begin
        if (reset) begin
            db_state_d <= 1'b0;
            press      <= 1'b0;
        end else begin
            db_state_d <= db_state;
            press      <= db_state & ~db_state_d;
        end
    end

    // View selector advances once per press and wraps naturally at 2 bits
    always_ff @(posedge clock) begin
        if (reset)
            mode <= 2'd0;
        else if (press)
            mode <= mode + 2'd1;
    end

    // Syscall value latch and saturating syscall counter
    always_ff @(posedge clock) begin
        if (reset) begin
            sys_val <= '0;
            sys_cnt <= '0;
        end else if (syscall_valid) begin
            sys_val <= syscall_value;
            if (sys_cnt != '1)
                sys_cnt <= sys_cnt + 32'd1;
        end
    end

    // Saturating run-cycle counter, frozen while the CPU is halted
    always_ff @(posedge clock) begin
        if (reset)
            cyc_cnt <= '0;
        else if (!halted && cyc_cnt != '1)
            cyc_cnt <= cyc_cnt + 32'd1;
    end

    // Registered PC so the display path stays free of input-to-output comb
    always_ff @(posedge clock) begin
        if (reset)
            pc_q <= '0;
        else
            pc_q <= pc;
    end

    // Registered output mux driven from the current view and register state
    always_ff @(posedge clock) begin
        if (reset) begin
            data <= '0;
        end else begin
            case (mode)
                2'd0:    data <= sys_val;
                2'd1:    data <= pc_q;
                2'd2:    data <= cyc_cnt;
                default: data <= sys_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_display_source_select.sv
// Scoreboard bench for display_source_select. The bench pushes expected
// (edge, value) entries while it drives the stimulus. A negedge monitor
// compares each entry when its edge arrives.
module tb_display_source_select;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        syscall_valid;
    logic [31:0] syscall_value;
    logic [31:0] pc;
    logic        halted;
    logic        mode_button;
    logic [31:0] data;
    logic [1:0]  mode;

    display_source_select #(.DEBOUNCE_CYCLES(D)) dut (
        .clock         (clock),
        .reset         (reset),
        .syscall_valid (syscall_valid),
        .syscall_value (syscall_value),
        .pc            (pc),
        .halted        (halted),
        .mode_button   (mode_button),
        .data          (data),
        .mode          (mode)
    );

    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        int          at;
        bit          is_mode;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state known to the bench from its own stimulus
    logic [31:0] exp_sys_val = '0;
    logic [31:0] exp_sys_cnt = '0;
    logic [31:0] pc_const    = 32'hCAFE_0001;
    int          hstart      = 0;
    int          hstop       = 0;
    bit          cyc_sat     = 1'b0;
    int          cur_mode    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @edge %0d: got %h want %h", tag, edge_n, got, exp);
        end
    endtask

    function automatic void expect_at(input int at, input bit is_mode,
                                      input logic [31:0] v, input string tag);
        exp_t e;
        e.at = at; e.is_mode = is_mode; e.exp = v; e.tag = tag;
        sb.push_back(e);
    endfunction

    // Run cycles counted after edge x: edges in (hstart, min(x, hstop)]
    function automatic logic [31:0] cyc_after(input int x);
        int hi;
        hi = (x < hstop) ? x : hstop;
        return (hi > hstart) ? 32'(hi - hstart) : 32'd0;
    endfunction

    // Expected data at edge x for view m
    function automatic logic [31:0] view(input int m, input int x);
        case (m)
            0:       return exp_sys_val;
            1:       return pc_const;
            2:       return cyc_sat ? 32'hFFFF_FFFF : cyc_after(x - 1);
            default: return exp_sys_cnt;
        endcase
    endfunction

    // Compare every entry due at this edge. An entry past its edge is a failure.
    always @(negedge clock) begin
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].at == edge_n) begin
                chk(sb[i].tag, sb[i].is_mode ? {30'd0, mode} : data, sb[i].exp);
                sb.delete(i);
            end else if (sb[i].at < edge_n) begin
                chk({sb[i].tag, "_missed"}, 32'd1, 32'd0);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Clean press: raw rise sampled at edge k, mode at k+3+D, data at k+4+D
    task automatic press_clean(input int hold, input int rel);
        int k, old, nw, last;
        old  = cur_mode;
        nw   = (old + 1) % 4;
        k    = edge_n + 1;
        last = k - 1 + hold + rel;
        mode_button = 1'b1;
        expect_at(k + 2 + D, 1, 32'(old), $sformatf("mode_before_%0d", nw));
        expect_at(k + 3 + D, 0, view(old, k + 3 + D), $sformatf("data_before_%0d", nw));
        expect_at(k + 3 + D, 1, 32'(nw), $sformatf("mode_upd_%0d", nw));
        for (int x = k + 4 + D; x <= last; x++)
            expect_at(x, 0, view(nw, x), $sformatf("data_view_%0d", nw));
        expect_at(last, 1, 32'(nw), $sformatf("mode_hold_%0d", nw));
        cur_mode = nw;
        tick(hold);
        mode_button = 1'b0;
        tick(rel);
    endtask

    initial begin
        int e, k, r0;
        reset = 1'b1; syscall_valid = 1'b0; syscall_value = '0;
        pc = pc_const; halted = 1'b1; mode_button = 1'b0;
        tick(2);

        // Reset state, then idle while halted
        expect_at(edge_n, 0, 32'd0, "rst_data");
        expect_at(edge_n, 1, 32'd0, "rst_mode");
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            expect_at(edge_n + i, 0, 32'd0, "idle_data");
            expect_at(edge_n + i, 1, 32'd0, "idle_mode");
        end
        tick(10);

        // Four clean presses walk 1,2,3 and wrap to 0; cycle count stays 0
        repeat (4) press_clean(10, 10);

        // Syscall strobes in view 0, second one three cycles after the first
        e = edge_n;
        syscall_valid = 1'b1; syscall_value = 32'h1234_5678;
        expect_at(e + 1, 0, 32'd0, "sys_lat1");
        expect_at(e + 2, 0, 32'h1234_5678, "sys_first");
        expect_at(e + 4, 0, 32'h1234_5678, "sys_hold");
        expect_at(e + 5, 0, 32'hDEAD_BEEF, "sys_second");
        tick(1);
        syscall_valid = 1'b0;
        tick(2);
        syscall_valid = 1'b1; syscall_value = 32'hDEAD_BEEF;
        tick(1);
        syscall_valid = 1'b0;
        tick(3);
        exp_sys_val = 32'hDEAD_BEEF;
        exp_sys_cnt = 32'd2;

        // Bouncing button then a long hold: exactly one step to view 1
        for (int i = 0; i < 4; i++) begin
            mode_button = ~i[0];
            tick(1);
        end
        k = edge_n + 1;
        mode_button = 1'b1;
        expect_at(k + 2 + D, 1, 32'd0, "bounce_mode_before");
        expect_at(k + 3 + D, 1, 32'd1, "bounce_mode_upd");
        for (int i = 0; i < 20; i++) begin
            pc = 32'hA000_0000 + 32'(i * 7);
            if (edge_n + 2 <= k + 3 + D)
                expect_at(edge_n + 2, 0, 32'hDEAD_BEEF, "bounce_data_old");
            else
                expect_at(edge_n + 2, 0, pc, "pc_track");
            tick(1);
        end
        expect_at(edge_n, 1, 32'd1, "bounce_single");
        pc_const = pc;
        cur_mode = 1;
        mode_button = 1'b0;
        tick(10);

        // Run the CPU and show the cycle counter
        hstart = edge_n; hstop = 1 << 30;
        halted = 1'b0;
        press_clean(10, 10);

        // Halt: the counter freezes at the last counted edge
        hstop = edge_n;
        halted = 1'b1;
        for (int i = 1; i <= 5; i++)
            expect_at(edge_n + i, 0, view(2, edge_n + i), "halt_freeze");
        tick(5);

        // Saturation: preload near the top, then keep running
        e = edge_n;
        force dut.cyc_cnt = 32'hFFFF_FFFE;
        halted = 1'b0;
        for (int i = 3; i <= 8; i++)
            expect_at(e + i, 0, 32'hFFFF_FFFF, "cyc_saturate");
        tick(1);
        release dut.cyc_cnt;
        tick(7);
        cyc_sat = 1'b1;

        // Syscall count view
        press_clean(10, 10);

        // Reset two cycles into a held press: everything clears, then a full
        // debounce count is needed before the held button is accepted again
        halted = 1'b1;
        r0 = edge_n;
        mode_button = 1'b1;
        tick(3);
        reset = 1'b1;
        expect_at(r0 + 4, 0, 32'd0, "rst_mid_data");
        expect_at(r0 + 4, 1, 32'd0, "rst_mid_mode");
        expect_at(r0 + 11, 1, 32'd0, "rst_redeb_before");
        expect_at(r0 + 12, 1, 32'd1, "rst_redeb_mode");
        expect_at(r0 + 12, 0, 32'd0, "rst_redeb_sys");
        expect_at(r0 + 13, 0, pc_const, "rst_redeb_pc");
        tick(1);
        reset = 1'b0;
        tick(14);
        mode_button = 1'b0;
        tick(10);

        if (sb.size() != 0)
            chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
